// File: rtl/approx_mul_pipe.sv
// Three-stage unsigned W x W multiplier with per-transaction exact/approximate mode.
// Latency 3 cycles, one result per cycle; a stalled output freezes every stage and drops in_ready.
module approx_mul_pipe #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [2*W-1:0]   out_err,
    output logic             out_mode,
    output logic [15:0]      txn_count
);

    localparam int NP = W / 2;

    logic advance;

    // Stage 1: operand capture
    logic           s1_vld_q,  s1_vld_d;
    logic [W-1:0]   s1_x_q,    s1_x_d;
    logic [W-1:0]   s1_y_q,    s1_y_d;
    logic           s1_mode_q, s1_mode_d;

    // Stage 2: per-pair sums/carries and accumulated error
    logic           s2_vld_q,  s2_vld_d;
    logic [W:0]     s2_sum_q [NP];
    logic [W:0]     s2_sum_d [NP];
    logic [W:0]     s2_cry_q [NP];
    logic [W:0]     s2_cry_d [NP];
    logic [2*W-1:0] s2_err_q,  s2_err_d;
    logic           s2_mode_q, s2_mode_d;

    // Stage 3: final result
    logic           s3_vld_q,  s3_vld_d;
    logic [2*W-1:0] out_p_q,   out_p_d;
    logic [2*W-1:0] out_err_q, out_err_d;
    logic           out_mode_q, out_mode_d;
    logic [15:0]    txn_count_q, txn_count_d;

    logic [W:0]     amask;
    logic [W:0]     pa [NP];
    logic [W:0]     pb [NP];
    logic [W:0]     pboth [NP];
    logic [2*W-1:0] p_acc;

    assign advance   = !s3_vld_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_vld_q;
    assign out_p     = out_p_q;
    assign out_err   = out_err_q;
    assign out_mode  = out_mode_q;
    assign txn_count = txn_count_q;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_x_d    = s1_x_q;
        s1_y_d    = s1_y_q;
        s1_mode_d = s1_mode_q;
        if (advance) begin
            s1_vld_d  = in_valid;
            s1_x_d    = in_x;
            s1_y_d    = in_y;
            s1_mode_d = in_mode;
        end
    end

    // Columns below APPROX_COLS OR-merge only when the transaction asked for it.
    always_comb begin
        amask = '0;
        for (int c = 0; c <= W; c++) begin
            amask[c] = s1_mode_q && (c < APPROX_COLS);
        end
    end

    // Pair k: row 2k sits at columns 0..W-1, row 2k+1 is shifted up one column.
    always_comb begin
        for (int k = 0; k < NP; k++) begin
            pa[k]    = {1'b0, s1_y_q & {W{s1_x_q[2*k]}}};
            pb[k]    = {s1_y_q & {W{s1_x_q[2*k+1]}}, 1'b0};
            pboth[k] = pa[k] & pb[k];
        end
    end

    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_err_d  = s2_err_q;
        s2_mode_d = s2_mode_q;
        for (int k = 0; k < NP; k++) begin
            s2_sum_d[k] = s2_sum_q[k];
            s2_cry_d[k] = s2_cry_q[k];
        end
        if (advance) begin
            s2_vld_d  = s1_vld_q;
            s2_mode_d = s1_mode_q;
            s2_err_d  = '0;
            for (int k = 0; k < NP; k++) begin
                s2_sum_d[k] = (pa[k] ^ pb[k]) | (pboth[k] & amask);
                s2_cry_d[k] = pboth[k] & ~amask;
                // An OR-merged 1+1 column loses exactly its own weight.
                s2_err_d    = s2_err_d
                            + ({{(W-1){1'b0}}, pboth[k] & amask} << (2*k));
            end
        end
    end

    always_comb begin
        p_acc = '0;
        for (int k = 0; k < NP; k++) begin
            p_acc = p_acc + ({{(W-2){1'b0}},
                              ({1'b0, s2_sum_q[k]} + {s2_cry_q[k], 1'b0})} << (2*k));
        end
    end

    always_comb begin
        s3_vld_d   = s3_vld_q;
        out_p_d    = out_p_q;
        out_err_d  = out_err_q;
        out_mode_d = out_mode_q;
        if (advance) begin
            s3_vld_d   = s2_vld_q;
            out_p_d    = p_acc;
            out_err_d  = s2_err_q;
            out_mode_d = s2_mode_q;
        end
    end

    always_comb begin
        txn_count_d = txn_count_q;
        if (s3_vld_q && out_ready) begin
            txn_count_d = txn_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_mode_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_err_q    <= '0;
            s2_mode_q   <= 1'b0;
            for (int k = 0; k < NP; k++) begin
                s2_sum_q[k] <= '0;
                s2_cry_q[k] <= '0;
            end
            s3_vld_q    <= 1'b0;
            out_p_q     <= '0;
            out_err_q   <= '0;
            out_mode_q  <= 1'b0;
            txn_count_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_mode_q   <= s1_mode_d;
            s2_vld_q    <= s2_vld_d;
            s2_err_q    <= s2_err_d;
            s2_mode_q   <= s2_mode_d;
            for (int k = 0; k < NP; k++) begin
                s2_sum_q[k] <= s2_sum_d[k];
                s2_cry_q[k] <= s2_cry_d[k];
            end
            s3_vld_q    <= s3_vld_d;
            out_p_q     <= out_p_d;
            out_err_q   <= out_err_d;
            out_mode_q  <= out_mode_d;
            txn_count_q <= txn_count_d;
        end
    end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe: directed table, stall/reset sequences, random traffic.
module tb_approx_mul_pipe;

    localparam int W  = 8;
    localparam int AC = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic [2*W-1:0] out_err;
    logic           out_mode;
    logic [15:0]    txn_count;

    always #5 clk = ~clk;

    approx_mul_pipe #(.W(W), .APPROX_COLS(AC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_err   (out_err),
        .out_mode  (out_mode),
        .txn_count (txn_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Error = weight of every approximate column where both partial-product bits are 1.
    function automatic longint ref_err(input int x, input int y, input bit mode);
        longint e = 0;
        int a, b;
        if (mode) begin
            for (int k = 0; k < W/2; k++) begin
                for (int c = 0; c < AC; c++) begin
                    a = 0;
                    b = 0;
                    if (c < W) a = (x >> (2*k)) & (y >> c) & 1;
                    if (c > 0) b = (x >> (2*k+1)) & (y >> (c-1)) & 1;
                    if (a == 1 && b == 1) e += longint'(1) << (2*k + c);
                end
            end
        end
        return e;
    endfunction

    typedef struct { int x; int y; bit mode; } txn_t;
    txn_t exp_q[$];

    logic [15:0]    hs_cnt = '0;
    logic           prev_stall = 1'b0;
    logic [2*W-1:0] prev_p, prev_err;
    logic           prev_mode;

    always @(negedge clk) begin
        txn_t   t;
        longint e;
        if (rst) begin
            exp_q.delete();
            hs_cnt     = '0;
            prev_stall = 1'b0;
        end else begin
            check("txn_count", txn_count, hs_cnt);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_p", out_p, prev_p);
                check("hold_err", out_err, prev_err);
                check("hold_mode", out_mode, prev_mode);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    e = ref_err(t.x, t.y, t.mode);
                    check("model_p", out_p, longint'(t.x * t.y) - e);
                    check("model_err", out_err, e);
                    check("model_mode", out_mode, t.mode);
                    check("p_plus_err", longint'(out_p) + longint'(out_err), t.x * t.y);
                end
                hs_cnt = hs_cnt + 16'd1;
            end
            if (in_valid && in_ready) exp_q.push_back('{int'(in_x), int'(in_y), in_mode});
            prev_stall = out_valid && !out_ready;
            prev_p     = out_p;
            prev_err   = out_err;
            prev_mode  = out_mode;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_one(input int x, input int y, input bit mode,
                            output int lat, output longint gp, output longint ge,
                            output longint gm);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_x     = W'(x);
        in_y     = W'(y);
        in_mode  = mode;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        gp  = -1;
        ge  = -1;
        gm  = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                gp  = out_p;
                ge  = out_err;
                gm  = out_mode;
                break;
            end
        end
    endtask

    typedef struct { int x; int y; bit mode; int exp_p; int exp_err; } vec_t;
    vec_t tbl[12];

    int     lat;
    longint gp, ge, gm;
    int     sent;
    int     sx[10], sy[10];

    initial begin
        tbl[0]  = '{255, 255, 1'b0, 65025,    0};
        tbl[1]  = '{255, 255, 1'b1, 63835, 1190};
        tbl[2]  = '{  3,   3, 1'b1,     7,    2};
        tbl[3]  = '{  3,   3, 1'b0,     9,    0};
        tbl[4]  = '{  0,   0, 1'b1,     0,    0};
        tbl[5]  = '{  2,   3, 1'b0,     6,    0};
        tbl[6]  = '{  1, 255, 1'b1,   255,    0};
        tbl[7]  = '{128, 128, 1'b1, 16384,    0};
        tbl[8]  = '{  2,   1, 1'b1,     2,    0};
        tbl[9]  = '{  6,   6, 1'b1,    36,    0};
        tbl[10] = '{ 15,  15, 1'b1,   155,   70};
        tbl[11] = '{ 15,  15, 1'b0,   225,    0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_txn_count", txn_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            send_one(tbl[i].x, tbl[i].y, tbl[i].mode, lat, gp, ge, gm);
            check("tbl_latency", lat, 3);
            check("tbl_p", gp, tbl[i].exp_p);
            check("tbl_err", ge, tbl[i].exp_err);
            check("tbl_mode", gm, tbl[i].mode);
        end

        // Ten alternating-mode transactions, consumer stalls cycles 5..8.
        for (int i = 0; i < 10; i++) begin
            sx[i] = $urandom_range(0, 255);
            sy[i] = $urandom_range(0, 255);
        end
        sent = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc <= 8);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_x     = W'(sx[sent]);
                in_y     = W'(sy[sent]);
                in_mode  = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 5 && cyc <= 8) check("stream_stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) sent++;
            if (sent == 10 && !in_valid && exp_q.size() == 0 && !out_valid) break;
        end
        check("stream_sent", sent, 10);
        check("stream_txn_count", txn_count, 22);

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 8'd7;
        in_y      = 8'd9;
        in_mode   = 1'b0;
        @(posedge clk); #1;
        in_x      = 8'd11;
        in_y      = 8'd13;
        in_mode   = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 0);
        end
        check("post_rst_txn_count", txn_count, 0);
        send_one(2, 3, 1'b0, lat, gp, ge, gm);
        check("post_rst_latency", lat, 3);
        check("post_rst_p", gp, 6);
        check("post_rst_err", ge, 0);

        // Random traffic with random backpressure, both modes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_mode   = 1'($urandom_range(0, 1));
            in_x      = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom_range(0, 255));
            in_y      = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_no_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
